// File: rtl/show_query_ctrl_if.sv
// Bus bundle between the SHOW-mode query controller and its surroundings.
//   Inputs to the controller : active, rx_data, rx_done, store_count,
//                              tx_busy, ext_busy
//   Outputs of the controller: req_m, req_n, cursor, id, send_one,
//                              prompt_start, prompt_sel, done, err
// master = controller side, slave = environment (UART RX/TX, storage, top).
interface show_query_ctrl_if #(
  parameter int unsigned CNT_W = 3
);
  logic             active;
  logic [7:0]       rx_data;
  logic             rx_done;
  logic [CNT_W-1:0] store_count;
  logic             tx_busy;
  logic             ext_busy;
  logic [7:0]       req_m;
  logic [7:0]       req_n;
  logic [CNT_W-1:0] cursor;
  logic [7:0]       id;
  logic             send_one;
  logic             prompt_start;
  logic [2:0]       prompt_sel;
  logic             done;
  logic             err;

  modport master (
    input  active, rx_data, rx_done, store_count, tx_busy, ext_busy,
    output req_m, req_n, cursor, id, send_one, prompt_start, prompt_sel,
           done, err
  );

  modport slave (
    output active, rx_data, rx_done, store_count, tx_busy, ext_busy,
    input  req_m, req_n, cursor, id, send_one, prompt_start, prompt_sel,
           done, err
  );
endinterface

// File: rtl/show_query_ctrl.sv
// SHOW-mode query controller.
// Parses an (m, n) size request from UART RX bytes, waits STORE_LAT cycles
// for storage to re-index, then streams every stored matrix of that size to
// the matrix UART one at a time (send_one / tx_busy handshake). User prompts
// are held in a single overwrite slot and launched only while both UART
// sources are idle.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   bus   - show_query_ctrl_if.master (request parsing, send and prompt
//           handshakes, done/err pulses)
module show_query_ctrl #(
  parameter int unsigned MAX_DIM      = 5,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned MAX_PER_SIZE = 2,
  parameter int unsigned STORE_LAT    = 2,
  parameter int unsigned TIMEOUT_CYC  = 0,
  parameter int unsigned BUSY_GUARD   = 16,
  parameter int unsigned ID_BASE      = 1,
  parameter logic [7:0]  ABORT_CHAR   = 8'h1B
) (
  input logic               clk,
  input logic               rst_n,
  show_query_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_M, WAIT_N, PREP, SEND_ARM, SEND_HI, SEND_LO
  } state_t;

  typedef enum logic [2:0] {
    P_WAIT1   = 3'd0,
    P_WAIT2   = 3'd1,
    P_DISPLAY = 3'd2,
    P_EMPTY   = 3'd3,
    P_ERROR   = 3'd4
  } prompt_t;

  // One shared timer serves the WAIT_N timeout, the PREP latency and the
  // SEND_HI busy guard; it is cleared on every state change.
  localparam int unsigned T_MAX0 = (STORE_LAT > BUSY_GUARD) ? STORE_LAT : BUSY_GUARD;
  localparam int unsigned T_MAX  = (TIMEOUT_CYC > T_MAX0) ? TIMEOUT_CYC : T_MAX0;
  localparam int unsigned TMR_W  = $clog2(T_MAX + 1);
  localparam logic [TMR_W-1:0] PREP_LAST  = TMR_W'(STORE_LAT - 1);
  localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'(BUSY_GUARD - 1);
  localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [7:0]       DIG_HI     = 8'(48 + MAX_DIM);

  state_t           state, state_d;
  logic [TMR_W-1:0] tmr;
  logic             pending;
  prompt_t          pend_sel;
  logic [CNT_W-1:0] cnt_q, cnt_eff;
  logic             abort_q;

  logic       byte_v, is_digit, is_ws, is_abort, is_bad;
  logic       in_list, abort_now, abort_any, more;
  logic       launch, arm_go, send_fin, prep_end, to_hit;
  logic [CNT_W:0] cur_nxt;

  // output-process results, registered in the datapath
  logic    q_req, send_d, done_d, err_d, cur_step, set_m, set_n;
  prompt_t q_sel;

  // ---------------- shared decode ----------------
  assign byte_v   = bus.active && bus.rx_done;
  assign is_digit = (bus.rx_data >= 8'h31) && (bus.rx_data <= DIG_HI);
  assign is_ws    = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
  assign is_abort = (bus.rx_data == ABORT_CHAR);
  assign is_bad   = !is_digit && !is_ws && !is_abort;

  always_comb begin
    cnt_eff = bus.store_count;
    if (32'(bus.store_count) > MAX_PER_SIZE) cnt_eff = CNT_W'(MAX_PER_SIZE);
  end

  assign in_list   = (state == PREP) || (state == SEND_ARM) ||
                     (state == SEND_HI) || (state == SEND_LO);
  // An abort arriving on the exit cycle itself is honoured too.
  assign abort_now = byte_v && is_abort && in_list;
  assign abort_any = abort_q || abort_now;
  assign cur_nxt   = {1'b0, bus.cursor} + (CNT_W+1)'(1);
  assign more      = (cur_nxt < {1'b0, cnt_q}) && !abort_any;

  assign launch   = pending && !bus.tx_busy && !bus.ext_busy && bus.active;
  assign arm_go   = (state == SEND_ARM) && !bus.tx_busy && !pending;
  assign send_fin = ((state == SEND_LO) && !bus.tx_busy) ||
                    ((state == SEND_HI) && !bus.tx_busy && (tmr == GUARD_LAST));
  assign prep_end = (state == PREP) && (tmr == PREP_LAST);
  assign to_hit   = (TIMEOUT_CYC != 0) && (state == WAIT_N) && !bus.rx_done &&
                    (tmr == TO_LAST);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state;
    if (!bus.active) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE:     state_d = WAIT_M;
        WAIT_M:   if (byte_v && is_digit) state_d = WAIT_N;
        WAIT_N: begin
          if (byte_v && is_digit)                  state_d = PREP;
          else if ((byte_v && is_abort) || to_hit) state_d = WAIT_M;
        end
        PREP:     if (prep_end) state_d = ((cnt_eff == '0) || abort_any) ? WAIT_M : SEND_ARM;
        SEND_ARM: if (arm_go) state_d = SEND_HI;
        SEND_HI: begin
          if (bus.tx_busy)   state_d = SEND_LO;
          else if (send_fin) state_d = more ? SEND_ARM : WAIT_M;
        end
        SEND_LO:  if (send_fin) state_d = more ? SEND_ARM : WAIT_M;
        default:  state_d = IDLE;
      endcase
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    q_req    = 1'b0;
    q_sel    = P_WAIT1;
    send_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cur_step = 1'b0;
    set_m    = 1'b0;
    set_n    = 1'b0;
    if (bus.active) begin
      unique case (state)
        IDLE: q_req = 1'b1;
        WAIT_M: begin
          if (byte_v && is_digit) begin
            set_m = 1'b1; q_req = 1'b1; q_sel = P_WAIT2;
          end else if (byte_v && is_bad) begin
            err_d = 1'b1; q_req = 1'b1; q_sel = P_ERROR;
          end
        end
        WAIT_N: begin
          if (byte_v && is_digit) begin
            set_n = 1'b1; q_req = 1'b1; q_sel = P_DISPLAY;
          end else if (byte_v && is_abort) begin
            q_req = 1'b1; q_sel = P_WAIT1;
          end else if (byte_v && is_bad) begin
            err_d = 1'b1; q_req = 1'b1; q_sel = P_ERROR;
          end else if (to_hit) begin
            err_d = 1'b1; q_req = 1'b1; q_sel = P_WAIT1;
          end
        end
        PREP: begin
          if (prep_end && (cnt_eff == '0)) begin
            q_req = 1'b1; q_sel = P_EMPTY;
          end else if (prep_end && abort_any) begin
            q_req = 1'b1; q_sel = P_WAIT1;
          end
        end
        SEND_ARM: send_d = arm_go;
        SEND_HI, SEND_LO: begin
          if (send_fin) begin
            cur_step = 1'b1;
            if (!more) begin
              done_d = 1'b1; q_req = 1'b1; q_sel = P_WAIT1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.req_m        <= 8'd1;
      bus.req_n        <= 8'd1;
      bus.cursor       <= '0;
      bus.prompt_sel   <= 3'(P_WAIT1);
      bus.prompt_start <= 1'b0;
      bus.send_one     <= 1'b0;
      bus.done         <= 1'b0;
      bus.err          <= 1'b0;
      pending          <= 1'b0;
      pend_sel         <= P_WAIT1;
      tmr              <= '0;
      cnt_q            <= '0;
      abort_q          <= 1'b0;
    end else begin
      bus.send_one     <= send_d;
      bus.done         <= done_d;
      bus.err          <= err_d;
      bus.prompt_start <= launch;
      if (launch) bus.prompt_sel <= 3'(pend_sel);

      // A fresh request replaces whatever is still waiting, even if the old
      // one is being launched in this same cycle.
      if (!bus.active) begin
        pending <= 1'b0;
      end else if (q_req) begin
        pending  <= 1'b1;
        pend_sel <= q_sel;
      end else if (launch) begin
        pending <= 1'b0;
      end

      if (set_m) bus.req_m <= bus.rx_data - 8'h30;
      if (set_n) bus.req_n <= bus.rx_data - 8'h30;

      if ((state_d == IDLE) || (state_d == PREP)) bus.cursor <= '0;
      else if (cur_step)                          bus.cursor <= bus.cursor + CNT_W'(1);

      if (prep_end) cnt_q <= cnt_eff;

      if (in_list && (state_d == PREP || state_d == SEND_ARM ||
                      state_d == SEND_HI || state_d == SEND_LO))
        abort_q <= abort_any;
      else
        abort_q <= 1'b0;

      if ((state_d != state) || ((state == WAIT_N) && byte_v))
        tmr <= '0;
      else if ((state == WAIT_N) || (state == PREP) || (state == SEND_HI))
        tmr <= tmr + TMR_W'(1);
    end
  end

  assign bus.id = 8'(bus.cursor) + 8'(ID_BASE);

endmodule

// File: doc/show_query_ctrl.md
Name: show_query_ctrl

Overview:
- Parametrised successor to the SHOW-mode query controller. Parses a matrix size request (m, n) from UART RX bytes and waits a fixed latency for matrix storage to re-index.
- Streams every stored matrix of that size to the matrix UART transmitter, one at a time, using a proper busy handshake.
- Queues user prompts and launches each only when both UART sources are idle.
- Adds behaviour the previous controller lacked: whitespace skipping, an abort character, an N-digit timeout, an EMPTY prompt, an ERROR prompt, and busy-edge-qualified send completion.

Parameters:
- MAX_DIM, 5, largest legal digit for m and n (1..9).
- CNT_W, 3, width of the storage count and cursor.
- MAX_PER_SIZE, 2, upper clamp applied to store_count.
- STORE_LAT, 2, cycles spent in PREP before store_count is sampled (≥1).
- TIMEOUT_CYC, 0, cycles allowed in WAIT_N before reverting; 0 disables the timeout.
- BUSY_GUARD, 16, maximum cycles to wait for tx_busy to rise after send_one.
- ID_BASE, 1, offset added to cursor to form id.
- ABORT_CHAR, 8'h1B, abort byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- active  in  1  high while the top-level mode is SHOW
- rx_data  in  8  received byte; valid only when rx_done is high
- rx_done  in  1  one-cycle strobe marking a received byte
- store_count  in  CNT_W  number of stored matrices of size req_m x req_n
- tx_busy  in  1  matrix UART transmitter busy
- ext_busy  in  1  other UART source (mode notifier) busy
- req_m  out  8  requested row count
- req_n  out  8  requested column count
- cursor  out  CNT_W  index of the matrix currently being sent
- id  out  8  cursor + ID_BASE
- send_one  out  1  one-cycle pulse: send the matrix at cursor
- prompt_start  out  1  one-cycle pulse: emit prompt prompt_sel
- prompt_sel  out  3  prompt code: 0 WAIT1, 1 WAIT2, 2 DISPLAY, 3 EMPTY, 4 ERROR
- done  out  1  one-cycle pulse when a listing completes
- err  out  1  one-cycle pulse on an invalid byte or a timeout

Behaviour:
- Reset values (synchronous, rst_n low at a clk edge):
  - state = IDLE
  - req_m = req_n = 1
  - cursor = 0
  - prompt_sel = 0
  - all pulses = 0
  - pending prompt cleared; timers cleared.
- Byte classes:
  - digit: '1'..('0'+MAX_DIM)
  - whitespace: 0x20, 0x0D, 0x0A — always ignored, no prompt
  - abort: ABORT_CHAR
  - anything else is invalid.
- Effective count cnt = min(store_count, MAX_PER_SIZE).
- Prompt queue:
  - One pending slot. A new request overwrites any un-launched request.
  - Launch condition: pending && !tx_busy && !ext_busy && active. On launch, prompt_start pulses, prompt_sel is registered in the same cycle, and pending clears.
  - When active is low, pending clears.
- States and transitions:
  - IDLE: cursor = 0. When active, queue WAIT1 → WAIT_M.
  - WAIT_M: on a digit d, req_m = d, queue WAIT2 → WAIT_N. On an invalid byte, queue ERROR, pulse err, stay. Abort is ignored.
  - WAIT_N: on a digit d, req_n = d, queue DISPLAY → PREP. On abort, queue WAIT1 → WAIT_M. On an invalid byte, queue ERROR, pulse err, stay. If TIMEOUT_CYC > 0 and TIMEOUT_CYC cycles pass with no accepted byte, pulse err, queue WAIT1 → WAIT_M. The timer restarts on every rx_done, whitespace included.
  - PREP: hold STORE_LAT cycles with cursor = 0, then sample cnt. If cnt = 0, queue EMPTY → WAIT_M. Otherwise → SEND_ARM.
  - SEND_ARM: when !tx_busy && !pending, pulse send_one → SEND_HI.
  - SEND_HI: when tx_busy is seen high → SEND_LO. If BUSY_GUARD cycles pass without it, treat the send as complete and apply the SEND_LO exit rule.
  - SEND_LO: when tx_busy is low, cursor+1. If cursor+1 < cnt and no abort is latched → SEND_ARM. Otherwise pulse done, queue WAIT1 → WAIT_M.
- Abort during PREP or SEND_*: latched and applied at the next SEND_LO exit (or at PREP exit); the matrix in flight always completes. Any other byte in these states is ignored.
- Leaving SHOW: if active is low in any state, the next state is IDLE, no send_one or prompt_start is issued, and req_m/req_n hold their values. A byte arriving in the same cycle that active drops is ignored.
- Ordering: a prompt queued in the same cycle as a send is launched before the next send_one, because SEND_ARM waits on pending.
- Cursor: never exceeds MAX_PER_SIZE. id = cursor + ID_BASE, 8-bit, wraps modulo 256.

Test Plan:
- Reset, then active=1, ext_busy low → prompt_start with sel=0 within 2 cycles; req_m=req_n=1.
- Bytes '2', ' ', '2' with store_count=2 → req_m=2, req_n=2; prompts 1 then 2; after STORE_LAT, two send_one pulses with ids 1 and 2, each only after tx_busy has risen and fallen; then done and prompt 0.
- Bytes '3', '4' with store_count=0 → EMPTY prompt (3), no send_one, state returns to WAIT_M.
- Byte 'x' in WAIT_M → err pulse, prompt 4, req_m unchanged; byte '7' with MAX_DIM=5 behaves the same.
- TIMEOUT_CYC=100: byte '2', then silence for 100 cycles → err pulse, prompt 0, back to WAIT_M; a later '3' sets req_m=3.
- ESC during the first of 3 sends → that matrix completes, no second send_one, done pulse, prompt 0. Separately: drop active during SEND_HI → IDLE, no further pulses; ext_busy high blocks prompt_start until it falls.
